// File: rtl/fixed_point_squarer.sv
// Sequential unsigned fixed-point squarer.
// Computes X*X with a radix-2 shift-add datapath, one multiplier bit per cycle.
// The result keeps the operand's fixed-point scale.
// A saturated single-word copy and an overflow flag are also provided.
module fixed_point_squarer #(
  parameter int pWidth = 32,
  parameter int pScale = 17
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [pWidth-1:0]     iOperand,
  input  logic                  iInputReady,
  output logic                  oBusy,
  output logic                  oOutputReady,
  output logic [2*pWidth-1:0]   oResult,
  output logic [pWidth-1:0]     oResultWord,
  output logic                  oOverflow
);

  localparam int CW = $clog2(pWidth);
  localparam logic [CW-1:0] LAST_COUNT = CW'(pWidth - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [2*pWidth-1:0] acc_reg;
  logic [pWidth-1:0]   mcand_reg;
  logic [pWidth-1:0]   mult_reg;
  logic [CW-1:0]       count_reg;

  logic [2*pWidth-1:0] addend;
  logic [2*pWidth-1:0] acc_next;
  logic [2*pWidth-1:0] result_next;
  logic [pWidth-1:0]   word_next;
  logic                overflow_next;

  // Partial-product step and result formatting from the would-be next accumulator
  always_comb begin
    addend        = '0;
    if (mult_reg[0]) begin
      addend = {{pWidth{1'b0}}, mcand_reg} << count_reg;
    end
    acc_next      = acc_reg + addend;
    // Truncating scale-down: the low pScale fraction bits of the product are dropped.
    result_next   = acc_next >> pScale;
    overflow_next = |acc_next[2*pWidth-1:pWidth+pScale];
    word_next     = overflow_next ? '1 : result_next[pWidth-1:0];
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mult_reg     <= '0;
      count_reg    <= '0;
      oBusy        <= 1'b0;
      oOutputReady <= 1'b0;
      oResult      <= '0;
      oResultWord  <= '0;
      oOverflow    <= 1'b0;
    end else begin
      oOutputReady <= 1'b0;
      case (state_reg)
        CALC: begin
          acc_reg   <= acc_next;
          mult_reg  <= mult_reg >> 1;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_COUNT) begin
            state_reg    <= DONE;
            oBusy        <= 1'b0;
            oOutputReady <= 1'b1;
            oResult      <= result_next;
            oResultWord  <= word_next;
            oOverflow    <= overflow_next;
          end
        end
        default: begin
          // IDLE and DONE both accept; a request seen in DONE starts back-to-back.
          if (iInputReady) begin
            state_reg <= CALC;
            mcand_reg <= iOperand;
            mult_reg  <= iOperand;
            acc_reg   <= '0;
            count_reg <= '0;
            oBusy     <= 1'b1;
          end else begin
            state_reg <= IDLE;
            oBusy     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_squarer.sv
// Scoreboard bench for fixed_point_squarer: stimulus pushes expected results,
// a negedge monitor pops and compares whenever oOutputReady is seen.
module tb_fixed_point_squarer;

  localparam int W = 32;
  localparam int S = 17;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [W-1:0]    iOperand;
  logic            iInputReady;
  logic            oBusy;
  logic            oOutputReady;
  logic [2*W-1:0]  oResult;
  logic [W-1:0]    oResultWord;
  logic            oOverflow;

  fixed_point_squarer #(.pWidth(W), .pScale(S)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iOperand     (iOperand),
    .iInputReady  (iInputReady),
    .oBusy        (oBusy),
    .oOutputReady (oOutputReady),
    .oResult      (oResult),
    .oResultWord  (oResultWord),
    .oOverflow    (oOverflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2*W-1:0] res;
    logic [W-1:0]   word;
    logic           ovf;
    logic [W-1:0]   op;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   n_accepted = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: full-precision square, truncating scale-down, word saturation.
  function automatic exp_t model(input logic [W-1:0] x);
    exp_t e;
    logic [2*W-1:0] p;
    p      = 64'(x) * 64'(x);
    e.res  = p / (64'd1 << S);
    e.ovf  = (p >= (64'd1 << (W + S)));
    e.word = e.ovf ? 32'hFFFFFFFF : e.res[W-1:0];
    e.op   = x;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] x, input logic [2*W-1:0] r,
                              input logic [W-1:0] w, input logic o);
    exp_t e;
    e.res = r; e.word = w; e.ovf = o; e.op = x;
    return e;
  endfunction

  // Monitor: compare every result pulse against the oldest pending expectation
  always @(negedge Clock) begin
    if (!Reset && oOutputReady) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got result %h, expected no pulse", oResult);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("result op=%h", e.op), oResult, e.res);
        check($sformatf("word op=%h", e.op), 64'(oResultWord), 64'(e.word));
        check($sformatf("ovf op=%h", e.op), 64'(oOverflow), 64'(e.ovf));
        $display("txn op=%h result=%h word=%h ovf=%0d", e.op, oResult, oResultWord, oOverflow);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a one-cycle request; the expectation is queued only when the request will be accepted.
  task automatic issue(input logic [W-1:0] op, input exp_t e, input bit expect_accept);
    iOperand    = op;
    iInputReady = 1'b1;
    if (expect_accept) begin
      exp_q.push_back(e);
      n_accepted++;
    end
    tick();
    iInputReady = 1'b0;
    busy_cnt = oBusy ? 1 : 0;
  endtask

  // Wait for the result pulse, bounded; returns edges elapsed since the accept edge.
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (oBusy) busy_cnt++;
      if (oOutputReady) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no oOutputReady within 40 cycles, expected one at 32");
    end
  endtask

  task automatic run_one(input logic [W-1:0] op, input exp_t e);
    int k;
    issue(op, e, 1'b1);
    wait_done(k);
    check($sformatf("latency op=%h", op), 64'(k), 64'd32);
    check($sformatf("busy_cycles op=%h", op), 64'(busy_cnt), 64'd32);
    tick();
    check($sformatf("pulse_width op=%h", op), 64'(oOutputReady), 64'd0);
  endtask

  initial begin
    int k;
    int p0;
    exp_t dummy;
    dummy = mk(0, 0, 0, 0);
    Reset = 1'b1;
    iInputReady = 1'b0;
    iOperand = '0;
    repeat (3) tick();
    check("reset_busy", 64'(oBusy), 0);
    check("reset_ready", 64'(oOutputReady), 0);
    check("reset_result", oResult, 0);
    check("reset_word", 64'(oResultWord), 0);
    check("reset_ovf", 64'(oOverflow), 0);
    Reset = 1'b0;
    tick();

    // 2.0 squared
    run_one(32'h40000, mk(32'h40000, 64'h80000, 32'h80000, 1'b0));

    // Back-to-back: second request issued in DONE
    issue(32'h30000, mk(32'h30000, 64'h48000, 32'h48000, 1'b0), 1'b1);
    wait_done(k);
    check("b2b_first_latency", 64'(k), 64'd32);
    issue(32'h140000, mk(32'h140000, 64'hC80000, 32'hC80000, 1'b0), 1'b1);
    wait_done(k);
    check("b2b_interval", 64'(k + 1), 64'd33);
    tick();

    // Boundaries
    run_one(32'h0, mk(32'h0, 64'h0, 32'h0, 1'b0));
    run_one(32'h1, mk(32'h1, 64'h0, 32'h0, 1'b0));
    run_one(32'h16A09E6, model(32'h16A09E6));
    check("model_sqrt2_no_ovf", 64'(oOverflow), 64'd0);
    run_one(32'hFFFFFFFF, mk(32'hFFFFFFFF, 64'h7FFFFFFF0000, 32'hFFFFFFFF, 1'b1));

    // Request during CALC cycle 10 is ignored
    p0 = n_pulses;
    issue(32'h50000, model(32'h50000), 1'b1);
    repeat (9) tick();
    iOperand = 32'h70000;
    iInputReady = 1'b1;
    tick();
    iInputReady = 1'b0;
    wait_done(k);
    check("ignored_req_latency", 64'(k + 10), 64'd32);
    repeat (40) tick();
    check("ignored_req_pulses", 64'(n_pulses - p0), 64'd1);

    // Reset during CALC cycle 15 aborts without a pulse
    p0 = n_pulses;
    issue(32'h40000, dummy, 1'b0);
    repeat (14) tick();
    check("abort_busy_before", 64'(oBusy), 64'd1);
    Reset = 1'b1;
    tick();
    check("abort_busy", 64'(oBusy), 0);
    check("abort_ready", 64'(oOutputReady), 0);
    check("abort_result", oResult, 0);
    check("abort_word", 64'(oResultWord), 0);
    check("abort_ovf", 64'(oOverflow), 0);
    Reset = 1'b0;
    repeat (40) tick();
    check("abort_no_pulse", 64'(n_pulses - p0), 64'd0);
    run_one(32'h40000, mk(32'h40000, 64'h80000, 32'h80000, 1'b0));

    // Reset wins over a simultaneous request
    Reset = 1'b1;
    issue(32'h40000, dummy, 1'b0);
    Reset = 1'b0;
    tick();
    check("reset_vs_req_busy", 64'(oBusy), 0);

    // Random operands, mixing back-to-back and idle gaps
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] op;
      case ($urandom_range(0, 3))
        0:       op = $urandom_range(0, 32'h3FFFF);
        1:       op = $urandom_range(0, 32'h1FFFFFF);
        default: op = $urandom;
      endcase
      issue(op, model(op), 1'b1);
      wait_done(k);
      if (k != 32) check($sformatf("rand_latency op=%h", op), 64'(k), 64'd32);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    repeat (3) tick();
    check("pulse_count", 64'(n_pulses), 64'(n_accepted));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
